dbus_sram_responder: RTL and testbench

//  Memory-side responder for the core's data bus: accepts dbus requests from the pipeline's
//  MEM stage and returns the addr_ok/data_ok handshake plus 64-bit read data.

---
 rtl/dbus_sram_responder.sv | 124 ++++++++++++
 tb/tb_dbus_sram_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: word-addressed 64-bit memory with byte strobes,
// addr_ok/data_ok handshake and programmable response latency.
module dbus_sram_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    input  logic [3:0]  extra_wait,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dok_q, dok_d;
    logic [63:0]       rdata_q, rdata_d;

    logic [63:0]       mem [DEPTH];

    logic [63:0]       off_c;
    logic [63:0]       word_c;
    logic [63:0]       merged_c;
    logic [IDX_W-1:0]  idx_c;
    logic              in_range_c;
    logic              accept_c;
    logic [CNT_W-1:0]  load_c;
    logic              unused_size_c;

    assign unused_size_c = ^req_size;

    // Address decode and strobe merge against the currently stored word.
    always_comb begin
        off_c      = req_addr - BASE;
        idx_c      = off_c[IDX_W+2:3];
        in_range_c = (req_addr >= BASE) && ((off_c >> 3) < 64'(DEPTH));
        word_c     = mem[idx_c];
        for (int i = 0; i < 8; i++) begin
            merged_c[8*i +: 8] = req_strobe[i] ? req_data[8*i +: 8] : word_c[8*i +: 8];
        end
        accept_c = reset_n && (state_q == ST_IDLE) && req_valid;
        load_c   = CNT_W'(LATENCY - 1) + CNT_W'(extra_wait);
    end

    assign resp_addr_ok = accept_c;
    assign resp_data_ok = dok_q;
    assign resp_data    = rdata_q;

    // Next-state logic; response word is snapshotted at acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dok_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    rdata_d = in_range_c ? merged_c : 64'h0;
                    if (load_c == CNT_W'(0)) begin
                        state_d = ST_RESP;
                        dok_d   = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = load_c;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = CNT_W'(0);
                    state_d = ST_RESP;
                    dok_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_W'(0);
            dok_q   <= 1'b0;
            rdata_q <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dok_q   <= dok_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM array is deliberately not reset; writes commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept_c && in_range_c && (|req_strobe)) begin
            mem[idx_c] <= merged_c;
        end
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed self-checking bench for dbus_sram_responder (DEPTH=1024, LATENCY=2).
module tb_dbus_sram_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic [3:0]  extra_wait;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [63:0] resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    dbus_sram_responder #(
        .DEPTH   (1024),
        .LATENCY (2),
        .BASE    (BASE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_strobe   (req_strobe),
        .req_data     (req_data),
        .extra_wait   (extra_wait),
        .resp_addr_ok (resp_addr_ok),
        .resp_data_ok (resp_data_ok),
        .resp_data    (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction, starting and ending on a falling edge.
    task automatic do_req(input logic [63:0] addr, input logic [7:0] strb,
                          input logic [63:0] wdata, input logic [3:0] ew,
                          output logic [63:0] rdata, output int lat);
        logic busy_aok;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_size   = 3'd3;
        req_strobe = strb;
        req_data   = wdata;
        extra_wait = ew;
        #1;
        check_eq("addr_ok_idle", 64'(resp_addr_ok), 64'd1);
        lat      = -1;
        rdata    = 64'h0;
        busy_aok = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resp_data_ok) begin
                lat   = c;
                rdata = resp_data;
                break;
            end
            if (resp_addr_ok) busy_aok = 1'b1;
        end
        req_valid  = 1'b0;
        req_strobe = 8'h00;
        @(negedge clk);
        check_eq("data_ok_pulse", 64'(resp_data_ok), 64'd0);
        check_eq("addr_ok_busy", 64'(busy_aok), 64'd0);
    endtask

    logic [63:0] rd;
    int          lat;
    logic [63:0] a5 [3];
    logic [63:0] d5 [3];
    logic [63:0] got5 [3];
    int          aok_cyc [3];
    int          dok_cyc [3];
    int          ka;
    int          kd;
    logic        dok_seen;

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b1;
        req_addr   = BASE;
        req_size   = 3'd3;
        req_strobe = 8'h00;
        req_data   = 64'h0;
        extra_wait = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_addr_ok", 64'(resp_addr_ok), 64'd0);
        check_eq("rst_data_ok", 64'(resp_data_ok), 64'd0);
        check_eq("rst_resp_data", resp_data, 64'h0);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);

        // 1: full write then read
        do_req(BASE + 64'd8, 8'hFF, 64'h1122_3344_5566_7788, 4'd0, rd, lat);
        check_eq("t1_wr_resp", rd, 64'h1122_3344_5566_7788);
        check_eq("t1_wr_lat", 64'(lat), 64'd2);
        do_req(BASE + 64'd8, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t1_rd", rd, 64'h1122_3344_5566_7788);

        // 2: partial write; response carries the post-write word
        do_req(BASE + 64'd8, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 4'd0, rd, lat);
        check_eq("t2_wr_resp", rd, 64'h1122_3344_AAAA_BBBB);
        do_req(BASE + 64'd8, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t2_rd", rd, 64'h1122_3344_AAAA_BBBB);

        // 3: latency with and without extra wait
        do_req(BASE + 64'd8, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t3_lat_ew0", 64'(lat), 64'd2);
        do_req(BASE + 64'd8, 8'h00, 64'h0, 4'd3, rd, lat);
        check_eq("t3_lat_ew3", 64'(lat), 64'd5);
        check_eq("t3_data_ew3", rd, 64'h1122_3344_AAAA_BBBB);

        // 4: out-of-range reads/writes around the window edges
        do_req(BASE, 8'hFF, 64'h0000_0000_0000_A0A0, 4'd0, rd, lat);
        do_req(BASE + 64'd8 * 64'd1023, 8'hFF, 64'h0000_0000_0000_B1B1, 4'd0, rd, lat);
        do_req(BASE - 64'd8, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t4_rd_below", rd, 64'h0);
        check_eq("t4_lat_below", 64'(lat), 64'd2);
        do_req(BASE + 64'd8 * 64'd1024, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t4_rd_above", rd, 64'h0);
        check_eq("t4_lat_above", 64'(lat), 64'd2);
        do_req(BASE - 64'd8, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 4'd0, rd, lat);
        check_eq("t4_wr_below_resp", rd, 64'h0);
        do_req(BASE + 64'd8 * 64'd1024, 8'hFF, 64'hBEEF_BEEF_BEEF_BEEF, 4'd0, rd, lat);
        check_eq("t4_wr_above_resp", rd, 64'h0);
        do_req(BASE + 64'd8 * 64'd1023, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t4_last_word", rd, 64'h0000_0000_0000_B1B1);
        do_req(BASE, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t4_word0", rd, 64'h0000_0000_0000_A0A0);
        do_req(BASE + 64'd8, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t4_word1", rd, 64'h1122_3344_AAAA_BBBB);

        // 5: back-to-back reads with req_valid held high
        a5[0] = BASE + 64'h100; d5[0] = 64'h0101_0101_0101_0101;
        a5[1] = BASE + 64'h108; d5[1] = 64'h0202_0202_0202_0202;
        a5[2] = BASE + 64'h110; d5[2] = 64'h0303_0303_0303_0303;
        for (int i = 0; i < 3; i++) do_req(a5[i], 8'hFF, d5[i], 4'd0, rd, lat);
        for (int i = 0; i < 3; i++) begin
            aok_cyc[i] = -1;
            dok_cyc[i] = -1;
            got5[i]    = 64'h0;
        end
        ka = 0;
        kd = 0;
        req_valid  = 1'b1;
        req_strobe = 8'h00;
        req_addr   = a5[0];
        for (int c = 0; c < 30; c++) begin
            #1;
            if (resp_addr_ok && ka < 3) begin
                aok_cyc[ka] = c;
                ka++;
            end
            if (resp_data_ok && kd < 3) begin
                dok_cyc[kd] = c;
                got5[kd]    = resp_data;
                kd++;
                if (kd == 3) req_valid = 1'b0;
                else req_addr = a5[kd];
            end
            if (kd == 3) break;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t5_aok_cyc%0d", i), 64'(aok_cyc[i]), 64'(3 * i));
            check_eq($sformatf("t5_dok_cyc%0d", i), 64'(dok_cyc[i]), 64'(3 * i + 2));
            check_eq($sformatf("t5_data%0d", i), got5[i], d5[i]);
        end

        // 6: reset while a write is waiting
        req_valid  = 1'b1;
        req_addr   = BASE;
        req_strobe = 8'hFF;
        req_data   = 64'h6666_7777_8888_9999;
        extra_wait = 4'd5;
        #1;
        check_eq("t6_accept", 64'(resp_addr_ok), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_addr_ok", 64'(resp_addr_ok), 64'd0);
        dok_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_data_ok) dok_seen = 1'b1;
        end
        req_valid  = 1'b0;
        req_strobe = 8'h00;
        extra_wait = 4'd0;
        reset_n    = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (resp_data_ok) dok_seen = 1'b1;
        end
        check_eq("t6_no_data_ok", 64'(dok_seen), 64'd0);
        do_req(BASE, 8'h00, 64'h0, 4'd0, rd, lat);
        check_eq("t6_rd_lat", 64'(lat), 64'd2);
        check_eq("t6_rd_data", rd, 64'h6666_7777_8888_9999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
